// File: rtl/cdm8_err_meter.sv
// ============================================================================
// Module : cdm8_err_meter
// Error statistics accumulator for the cdm8 approximate multipliers.
// Build option: define CDM_ERR_SQ_EN to enable the squared-error sum.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cdm8_err_meter #(
    parameter int WIDTH       = 8,
    parameter int NUM_SAMPLES = 65536,
    parameter int CNT_W       = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2*WIDTH-1:0]       in_r,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [2*WIDTH+CNT_W-1:0] err_sum,
    output logic [2*WIDTH-1:0]       err_max,
    output logic [WIDTH-1:0]         max_a,
    output logic [WIDTH-1:0]         max_b,
    output logic [4*WIDTH+CNT_W-1:0] err_sq_sum,
    output logic                     busy,
    output logic                     done
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = PW + CNT_W;
    localparam int QW = 2 * PW + CNT_W;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_sample_cnt;

    logic               r_s0_valid;
    logic [WIDTH-1:0]   r_s0_a;
    logic [WIDTH-1:0]   r_s0_b;
    logic [PW-1:0]      r_s0_r;

    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic [PW-1:0]      r_s1_r;
    logic [PW-1:0]      r_s1_exact;

    logic [CNT_W-1:0]   r_err_cnt;
    logic [SW-1:0]      r_err_sum;
    logic [PW-1:0]      r_err_max;
    logic [WIDTH-1:0]   r_max_a;
    logic [WIDTH-1:0]   r_max_b;

    logic               w_accept;
    logic               w_start_run;
    logic [PW-1:0]      w_exact;
    logic [PW-1:0]      w_ed;
    logic               w_is_err;

    assign w_accept    = in_valid && r_in_ready && !clear;
    assign w_start_run = !clear && start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_exact     = {{WIDTH{1'b0}}, r_s0_a} * {{WIDTH{1'b0}}, r_s0_b};
    assign w_ed        = (r_s1_r >= r_s1_exact) ? (r_s1_r - r_s1_exact) : (r_s1_exact - r_s1_r);
    assign w_is_err    = (w_ed != '0);

    // Control FSM; DRAIN ends once both pipeline valid bits have emptied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sample_cnt <= '0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_sample_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_sample_cnt <= r_sample_cnt + 1'b1;
                        if (r_sample_cnt == C_LAST) begin
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!r_s0_valid && !r_s1_valid) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_a     <= '0;
            r_s0_b     <= '0;
            r_s0_r     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_r     <= '0;
            r_s1_exact <= '0;
        end else if (clear) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_a <= in_a;
                r_s0_b <= in_b;
                r_s0_r <= in_r;
            end
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_a     <= r_s0_a;
                r_s1_b     <= r_s0_b;
                r_s1_r     <= r_s0_r;
                r_s1_exact <= w_exact;
            end
        end
    end

    // Strict comparison keeps the operands of the earliest maximum on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_err_sum <= '0;
            r_err_max <= '0;
            r_max_a   <= '0;
            r_max_b   <= '0;
        end else if (clear || w_start_run) begin
            r_err_cnt <= '0;
            r_err_sum <= '0;
            r_err_max <= '0;
            r_max_a   <= '0;
            r_max_b   <= '0;
        end else if (r_s1_valid) begin
            r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, w_is_err};
            r_err_sum <= r_err_sum + SW'(w_ed);
            if (w_ed > r_err_max) begin
                r_err_max <= w_ed;
                r_max_a   <= r_s1_a;
                r_max_b   <= r_s1_b;
            end
        end
    end

`ifdef CDM_ERR_SQ_EN
    logic [QW-1:0]   r_err_sq_sum;
    logic [2*PW-1:0] w_ed_sq;

    assign w_ed_sq = {{PW{1'b0}}, w_ed} * {{PW{1'b0}}, w_ed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sq_sum <= '0;
        end else if (clear || w_start_run) begin
            r_err_sq_sum <= '0;
        end else if (r_s1_valid) begin
            r_err_sq_sum <= r_err_sq_sum + QW'(w_ed_sq);
        end
    end

    assign err_sq_sum = r_err_sq_sum;
`else
    assign err_sq_sum = '0;
`endif

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;
    assign err_sum    = r_err_sum;
    assign err_max    = r_err_max;
    assign max_a      = r_max_a;
    assign max_b      = r_max_b;

endmodule

`default_nettype wire

// File: tb/tb_cdm8_err_meter.sv
// ============================================================================
// Module : tb_cdm8_err_meter
// Randomized scoreboard bench for cdm8_err_meter with a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cdm8_err_meter;

    localparam int W  = 8;
    localparam int NS = 8;
    localparam int CW = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_a = '0;
    logic [W-1:0]      in_b = '0;
    logic [2*W-1:0]    in_r = '0;
    logic [CW-1:0]     sample_cnt;
    logic [CW-1:0]     err_cnt;
    logic [2*W+CW-1:0] err_sum;
    logic [2*W-1:0]    err_max;
    logic [W-1:0]      max_a;
    logic [W-1:0]      max_b;
    logic [4*W+CW-1:0] err_sq_sum;
    logic              busy;
    logic              done;

    cdm8_err_meter #(.WIDTH(W), .NUM_SAMPLES(NS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_r(in_r),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .err_sum(err_sum),
        .err_max(err_max), .max_a(max_a), .max_b(max_b),
        .err_sq_sum(err_sq_sum), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint cnt;
        longint ecnt;
        longint esum;
        longint emax;
        longint ma;
        longint mb;
        longint sq;
        int     done_cyc;
    } exp_t;

    exp_t sbq[$];

    bit [7:0]  sa[NS];
    bit [7:0]  sb[NS];
    bit [15:0] sr[NS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: error statistics straight from the definition of error distance.
    function automatic exp_t model();
        exp_t e;
        e = '{default: 0};
        e.cnt = NS;
        for (int i = 0; i < NS; i++) begin
            longint p, r, ed;
            p  = longint'(sa[i]) * longint'(sb[i]);
            r  = longint'(sr[i]);
            ed = (r >= p) ? r - p : p - r;
            if (ed != 0) e.ecnt++;
            e.esum += ed;
            if (ed > e.emax) begin
                e.emax = ed;
                e.ma   = sa[i];
                e.mb   = sb[i];
            end
`ifdef CDM_ERR_SQ_EN
            e.sq += ed * ed;
`endif
        end
        return e;
    endfunction

    function automatic bit [15:0] exact16(input int i);
        int p;
        p = int'(sa[i]) * int'(sb[i]);
        return 16'(p);
    endfunction

    task automatic rand_fill();
        for (int i = 0; i < NS; i++) begin
            int p, m;
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
            p = int'(sa[i]) * int'(sb[i]);
            m = $urandom_range(0, 3);
            case (m)
                0: sr[i] = 16'(p);
                1: sr[i] = 16'(p + $urandom_range(0, 3));
                2: sr[i] = 16'($urandom);
                default: sr[i] = 16'(p) ^ (16'd1 << $urandom_range(0, 15));
            endcase
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic run(input int bubble_pct);
        exp_t e;
        int   idx, guard, last, w;
        bit   v, rdy;
        e = model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; guard = 0; last = 0;
        while (idx < NS && guard < 400) begin
            v        = ($urandom_range(0, 99) >= bubble_pct);
            in_valid = v;
            in_a     = sa[idx];
            in_b     = sb[idx];
            in_r     = sr[idx];
            rdy      = in_ready;
            @(posedge clk); #1;
            guard++;
            if (v && rdy) begin
                idx++;
                last = cyc;
            end
        end
        in_valid = 1'b0;
        if (idx < NS) chk("run_accept_timeout", 64'(idx), 64'(NS));
        chk("ready_drop", 64'(in_ready), 64'd0);
        chk("sample_cnt", 64'(sample_cnt), 64'(NS));
        e.done_cyc = last + 3;
        sbq.push_back(e);
        w = 0;
        while (!done && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic feed_err(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a     = 8'($urandom_range(1, 255));
            in_b     = 8'($urandom_range(1, 255));
            in_r     = 16'(int'(in_a) * int'(in_b) + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
        chk({tag, "_err_cnt"},    64'(err_cnt),    64'd0);
        chk({tag, "_err_sum"},    64'(err_sum),    64'd0);
        chk({tag, "_err_max"},    64'(err_max),    64'd0);
        chk({tag, "_max_ab"},     64'({max_a, max_b}), 64'd0);
        chk({tag, "_err_sq_sum"}, 64'(err_sq_sum), 64'd0);
        chk({tag, "_busy"},       64'(busy),       64'd0);
        chk({tag, "_done"},       64'(done),       64'd0);
        chk({tag, "_in_ready"},   64'(in_ready),   64'd0);
    endtask

    // Monitor: each rising edge of done retires one scoreboard entry.
    initial begin
        exp_t e;
        bit   pd;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && !pd) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("m_sample_cnt", 64'(sample_cnt), 64'(e.cnt));
                    chk("m_err_cnt",    64'(err_cnt),    64'(e.ecnt));
                    chk("m_err_sum",    64'(err_sum),    64'(e.esum));
                    chk("m_err_max",    64'(err_max),    64'(e.emax));
                    chk("m_max_a",      64'(max_a),      64'(e.ma));
                    chk("m_max_b",      64'(max_b),      64'(e.mb));
                    chk("m_err_sq_sum", 64'(err_sq_sum), 64'(e.sq));
                    chk("m_done_latency", 64'(cyc),      64'(e.done_cyc));
                    chk("m_busy_at_done", 64'(busy),     64'd0);
                    chk("m_ready_at_done", 64'(in_ready), 64'd0);
                end
            end
            pd = (done === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3; in_r = 16'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("idle_ignores_valid");

        // Exact products, including the largest operands.
        sa[0] = 3;   sb[0] = 5;   sr[0] = 15;
        sa[1] = 255; sb[1] = 255; sr[1] = 16'd65025;
        sa[2] = 2;   sb[2] = 2;   sr[2] = 4;
        sa[3] = 0;   sb[3] = 7;   sr[3] = 0;
        for (int i = 4; i < NS; i++) begin
            sa[i] = 8'($urandom); sb[i] = 8'($urandom); sr[i] = exact16(i);
        end
        run(0);
        chk("plan1_err_cnt", 64'(err_cnt), 64'd0);

        // Error distances 4, 4, 1: the first of the tied maxima is kept.
        sa[0] = 10; sb[0] = 10; sr[0] = 96;
        sa[1] = 16; sb[1] = 16; sr[1] = 260;
        sa[2] = 1;  sb[2] = 1;  sr[2] = 0;
        for (int i = 3; i < NS; i++) begin
            sa[i] = 8'($urandom); sb[i] = 8'($urandom); sr[i] = exact16(i);
        end
        run(0);
        chk("plan2_err_sum", 64'(err_sum), 64'd9);
        chk("plan2_max_ab",  64'({max_a, max_b}), {48'd0, 8'd10, 8'd10});

        for (int i = 0; i < NS; i++) begin
            sa[i] = 8'($urandom); sb[i] = 8'($urandom); sr[i] = exact16(i);
        end
        sa[5] = 255; sb[5] = 255; sr[5] = 0;
        run(50);
        chk("plan3_err_max", 64'(err_max), 64'd65025);

        for (int k = 0; k < 20; k++) begin
            rand_fill();
            run((k % 2 == 0) ? 50 : 0);
        end

        // Clear with a sample on the input and two more still in flight.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed_err(3);
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_r = 16'd0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk_zero("clear");
        repeat (3) @(posedge clk);
        #1;
        chk("clear_flush_err_sum", 64'(err_sum), 64'd0);
        chk("clear_flush_err_cnt", 64'(err_cnt), 64'd0);
        start = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        chk("clear_beats_start", 64'(busy), 64'd0);
        rand_fill();
        run(0);

        // Asynchronous reset between edges abandons the run at once.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed_err(4);
        #3 rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_fill();
        run(50);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
